ifetch_queue: RTL

Instruction prefetch queue sitting directly upstream of the pipeline's IF/ID register. It generates sequential fetch addresses, issues them to the instruction memory over a valid/ready request channel, and accepts in-order responses. Instructions and their PCs are buffered in a small FIFO and presented to the core with a valid/ready handshake. A redirect from the branch path flushes the queue and discards stale in-flight responses.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_fifo.sv | 78 +++++++
 rtl/ifetch_queue_chk.sv | 18 +
 rtl/ifetch_queue.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP   = 32'd4;
    localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [INSTR_W-1:0] inst;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low bits of any incoming PC are dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & WORD_MASK;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetched {inst, pc} entries with flush; pointers wrap naturally (DEPTH is a power of two).
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop: a flush wins, push on full and pop on empty are ignored
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_push_s = push && (count_r != FULL_CNT);
            do_pop_s  = pop && (count_r != '0);
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/ifetch_queue_chk.sv
// Protocol checker for ifetch_queue: a kept response must always have a live request behind it.
module ifetch_queue_chk #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             rsp_valid,
    input logic             redirect,
    input logic [CNT_W-1:0] live,
    input logic [CNT_W-1:0] discard
);

    a_live_rsp_has_request: assert property (
        @(posedge clk) disable iff (reset)
        (rsp_valid && !redirect && (discard == '0)) |-> (live != '0)
    );

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order response buffering, redirect flush.
// Optional build macro IFETCH_BYPASS_EN forwards a response straight to the core when the queue is empty.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               req_valid,
    output logic [ADDR_W-1:0]  req_addr,
    input  logic               req_ready,
    input  logic               rsp_valid,
    input  logic [INSTR_W-1:0] rsp_data,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               inst_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int               CNT_W     = $clog2(DEPTH) + 1;
    localparam int               SUM_W     = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] rsp_pc_r;
    logic [CNT_W-1:0]  live_r;
    logic [CNT_W-1:0]  discard_r;
    logic [CNT_W-1:0]  count_s;
    logic [CNT_W-1:0]  pending_s;
    logic [CNT_W-1:0]  redirect_discard_s;
    logic [SUM_W-1:0]  inflight_s;
    logic [ADDR_W-1:0] redirect_base_s;
    logic              fire_s;
    logic              rsp_live_s;
    logic              rsp_drop_s;
    logic              bypass_s;
    logic              push_s;
    logic              pop_s;
    fetch_entry_t      push_data_s;
    fetch_entry_t      head_s;

    // Credit check, request issue and response classification
    always_comb begin
        inflight_s      = SUM_W'(count_s) + SUM_W'(live_r) + SUM_W'(discard_r);
        req_valid       = !reset && !redirect && (inflight_s < DEPTH_SUM);
        req_addr        = reset ? RESET_PC : fetch_pc_r;
        fire_s          = req_valid && req_ready;
        rsp_live_s      = rsp_valid && !redirect && (discard_r == '0);
        rsp_drop_s      = rsp_valid && !redirect && (discard_r != '0);
        redirect_base_s = align_pc(redirect_pc);
    end

    // Everything still outstanding at a redirect becomes stale; a response in that cycle retires one of them
    always_comb begin
        pending_s = discard_r + live_r;
        if (rsp_valid && (pending_s != '0)) begin
            redirect_discard_s = pending_s - CNT_ONE;
        end else begin
            redirect_discard_s = pending_s;
        end
    end

`ifdef IFETCH_BYPASS_EN
    assign bypass_s = rsp_live_s && (count_s == '0) && !reset;
`else
    assign bypass_s = 1'b0;
`endif

    // FIFO control and core-facing outputs
    always_comb begin
        push_s           = rsp_live_s && !(bypass_s && inst_ready);
        push_data_s.inst = rsp_data;
        push_data_s.pc   = rsp_pc_r;
        pop_s            = (count_s != '0) && inst_ready && !redirect;
        if (reset) begin
            inst_valid = 1'b0;
            inst       = '0;
            inst_pc    = '0;
        end else if (count_s != '0) begin
            inst_valid = 1'b1;
            inst       = head_s.inst;
            inst_pc    = head_s.pc;
        end else if (bypass_s) begin
            inst_valid = 1'b1;
            inst       = rsp_data;
            inst_pc    = rsp_pc_r;
        end else begin
            inst_valid = 1'b0;
            inst       = '0;
            inst_pc    = '0;
        end
    end

    // PC registers and in-flight credit counters
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            live_r     <= '0;
            discard_r  <= '0;
        end else if (redirect) begin
            fetch_pc_r <= redirect_base_s;
            rsp_pc_r   <= redirect_base_s;
            live_r     <= '0;
            discard_r  <= redirect_discard_s;
        end else begin
            if (fire_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (rsp_live_s) begin
                rsp_pc_r <= rsp_pc_r + PC_STEP;
            end
            case ({fire_s, rsp_live_s})
                2'b10:   live_r <= live_r + CNT_ONE;
                2'b01:   live_r <= live_r - CNT_ONE;
                default: live_r <= live_r;
            endcase
            if (rsp_drop_s) begin
                discard_r <= discard_r - CNT_ONE;
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    ifetch_queue_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .rsp_valid (rsp_valid),
        .redirect  (redirect),
        .live      (live_r),
        .discard   (discard_r)
    );

endmodule
